slink_axi_ini_rsp_arb: RTL and testbench

//  Response-return stage upstream of the initiator's A2L flow-control path.

---
 rtl/slink_axi_ini_rsp_arb.sv | 123 ++++++++++++
 tb/tb_slink_axi_ini_rsp_arb.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slink_axi_ini_rsp_arb.sv
// Arbitrates AXI B/R responses into A2L packet words through a registered
// 2-entry skid buffer; readies are registered, so a2l_ready never reaches them combinationally.
module slink_axi_ini_rsp_arb #(
  parameter int          AXI_DATA_WIDTH = 64,
  parameter int          A2L_DATA_WIDTH = 35 + AXI_DATA_WIDTH,
  parameter logic [7:0]  B_PKT_DT       = 8'h22,
  parameter logic [7:0]  R_PKT_DT       = 8'h24,
  parameter bit          R_BURST_LOCK   = 1'b1
) (
  input  logic                      axi_clk,
  input  logic                      axi_reset,
  input  logic                      enable,
  input  logic [7:0]                ini_bid,
  input  logic [1:0]                ini_bresp,
  input  logic                      ini_bvalid,
  output logic                      ini_bready,
  input  logic [7:0]                ini_rid,
  input  logic [AXI_DATA_WIDTH-1:0] ini_rdata,
  input  logic [1:0]                ini_rresp,
  input  logic                      ini_rlast,
  input  logic                      ini_rvalid,
  output logic                      ini_rready,
  output logic                      a2l_valid,
  input  logic                      a2l_ready,
  output logic [A2L_DATA_WIDTH-1:0] a2l_data,
  output logic [15:0]               b_count,
  output logic [15:0]               r_count,
  output logic                      busy
);

  typedef enum logic {ST_ARB, ST_RLOCK} state_t;

  localparam logic [15:0] B_WC = 16'd3;
  localparam logic [15:0] R_WC = 16'(2 + AXI_DATA_WIDTH / 8);

  state_t                    state, state_nxt;
  logic                      rr_r, rr_nxt;          // 0: B has priority, 1: R
  logic [A2L_DATA_WIDTH-1:0] mem [2];
  logic                      wr_ptr, rd_ptr;
  logic [1:0]                count, count_nxt;
  logic                      push_b, push_r, push, pop;
  logic                      grant_b, grant_r, room;
  logic [A2L_DATA_WIDTH-1:0] b_word, r_word, in_word;

  assign push_b = ini_bvalid & ini_bready;
  assign push_r = ini_rvalid & ini_rready;
  assign push   = push_b | push_r;
  assign pop    = a2l_valid & a2l_ready;

  assign count_nxt = count + {1'b0, push} - {1'b0, pop};
  assign room      = (count_nxt < 2'd2);

  always_comb begin
    b_word                        = '0;
    b_word[7:0]                   = B_PKT_DT;
    b_word[23:8]                  = B_WC;
    b_word[31:24]                 = ini_bid;
    b_word[33:32]                 = ini_bresp;
    r_word                        = '0;
    r_word[7:0]                   = R_PKT_DT;
    r_word[23:8]                  = R_WC;
    r_word[31:24]                 = ini_rid;
    r_word[33:32]                 = ini_rresp;
    r_word[34]                    = ini_rlast;
    r_word[35 +: AXI_DATA_WIDTH]  = ini_rdata;
    in_word                       = push_r ? r_word : b_word;
  end

  // Grant is evaluated against post-edge state so the registered ready
  // already reflects the pointer flip / lock caused by this cycle's beat.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_r;
    grant_b   = 1'b0;
    grant_r   = 1'b0;
    if (push_b) rr_nxt = 1'b1;
    if (push_r) begin
      rr_nxt = 1'b0;
      if (state == ST_ARB && !ini_rlast && R_BURST_LOCK) state_nxt = ST_RLOCK;
      else if (state == ST_RLOCK && ini_rlast)          state_nxt = ST_ARB;
    end
    if (state_nxt == ST_RLOCK)          grant_r = 1'b1;
    else if (ini_bvalid && ini_rvalid) begin
      grant_r = rr_nxt;
      grant_b = ~rr_nxt;
    end
    else if (ini_bvalid)                grant_b = 1'b1;
    else if (ini_rvalid)                grant_r = 1'b1;
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_reset) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= '0;
      state      <= ST_ARB;
      rr_r       <= 1'b0;
      ini_bready <= 1'b0;
      ini_rready <= 1'b0;
      b_count    <= '0;
      r_count    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count      <= count_nxt;
      state      <= state_nxt;
      rr_r       <= rr_nxt;
      ini_bready <= enable & room & grant_b;
      ini_rready <= enable & room & grant_r;
      if (push_b) b_count <= b_count + 16'd1;
      if (push_r) r_count <= r_count + 16'd1;
    end
  end

  assign a2l_valid = (count != 2'd0);
  assign a2l_data  = a2l_valid ? mem[rd_ptr] : '0;
  assign busy      = a2l_valid | (state == ST_RLOCK);

endmodule

// File: tb/tb_slink_axi_ini_rsp_arb.sv
// Scoreboard bench for slink_axi_ini_rsp_arb: accepted beats queue expected
// packet words, the output monitor pops and compares them in order.
module tb_slink_axi_ini_rsp_arb;

  localparam int DW = 64;
  localparam int AW = 35 + DW;

  logic          axi_clk = 1'b0;
  logic          axi_reset = 1'b0;
  logic          enable = 1'b1;
  logic [7:0]    ini_bid = '0;
  logic [1:0]    ini_bresp = '0;
  logic          ini_bvalid = 1'b0;
  logic          ini_bready;
  logic [7:0]    ini_rid = '0;
  logic [DW-1:0] ini_rdata = '0;
  logic [1:0]    ini_rresp = '0;
  logic          ini_rlast = 1'b0;
  logic          ini_rvalid = 1'b0;
  logic          ini_rready;
  logic          a2l_valid;
  logic          a2l_ready = 1'b1;
  logic [AW-1:0] a2l_data;
  logic [15:0]   b_count, r_count;
  logic          busy;

  int total = 0;
  int passed = 0;
  logic [AW-1:0] sb [$];
  logic [7:0]    out_dt [$];
  logic          out_last [$];

  slink_axi_ini_rsp_arb #(
    .AXI_DATA_WIDTH(DW), .A2L_DATA_WIDTH(AW),
    .B_PKT_DT(8'h22), .R_PKT_DT(8'h24), .R_BURST_LOCK(1'b1)
  ) dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset), .enable(enable),
    .ini_bid(ini_bid), .ini_bresp(ini_bresp), .ini_bvalid(ini_bvalid), .ini_bready(ini_bready),
    .ini_rid(ini_rid), .ini_rdata(ini_rdata), .ini_rresp(ini_rresp), .ini_rlast(ini_rlast),
    .ini_rvalid(ini_rvalid), .ini_rready(ini_rready),
    .a2l_valid(a2l_valid), .a2l_ready(a2l_ready), .a2l_data(a2l_data),
    .b_count(b_count), .r_count(r_count), .busy(busy)
  );

  always #5 axi_clk = ~axi_clk;

  function automatic logic [AW-1:0] mk_b(input logic [7:0] id, input logic [1:0] resp);
    logic [AW-1:0] w;
    w = '0;
    w[7:0] = 8'h22; w[23:8] = 16'd3; w[31:24] = id; w[33:32] = resp;
    return w;
  endfunction

  function automatic logic [AW-1:0] mk_r(input logic [7:0] id, input logic [1:0] resp,
                                         input logic last, input logic [DW-1:0] d);
    logic [AW-1:0] w;
    w = '0;
    w[7:0] = 8'h24; w[23:8] = 16'd10; w[31:24] = id; w[33:32] = resp;
    w[34] = last; w[35 +: DW] = d;
    return w;
  endfunction

  // Output side pops before input side pushes: a word leaving now was accepted earlier.
  always @(negedge axi_clk) begin
    if (axi_reset) begin
      if (a2l_valid && a2l_ready) begin
        total++;
        if (sb.size() == 0)
          $display("FAIL sb_underflow: got %h, expected no word", a2l_data);
        else begin
          logic [AW-1:0] e;
          e = sb.pop_front();
          if (a2l_data !== e) $display("FAIL sb_word: got %h, expected %h", a2l_data, e);
          else passed++;
        end
        out_dt.push_back(a2l_data[7:0]);
        out_last.push_back(a2l_data[34]);
      end
      if (ini_bvalid && ini_bready) sb.push_back(mk_b(ini_bid, ini_bresp));
      if (ini_rvalid && ini_rready) sb.push_back(mk_r(ini_rid, ini_rresp, ini_rlast, ini_rdata));
      if (ini_bready && ini_rready) begin
        total++;
        $display("FAIL ready_exclusive: bready=%b rready=%b, expected not both", ini_bready, ini_rready);
      end
    end
  end

  task automatic hold_reset(input int cycles);
    @(posedge axi_clk); #1;
    axi_reset = 1'b0; ini_bvalid = 1'b0; ini_rvalid = 1'b0;
    repeat (cycles) @(posedge axi_clk);
    sb.delete(); out_dt.delete(); out_last.delete();
    #1 axi_reset = 1'b1;
  endtask

  task automatic send_b(input logic [7:0] id, input logic [1:0] resp);
    bit ok = 1'b0;
    ini_bid = id; ini_bresp = resp; ini_bvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge axi_clk);
      if (ini_bready) begin ok = 1'b1; break; end
    end
    if (!ok) begin total++; $display("FAIL send_b_timeout: bready=0, expected 1"); end
    @(posedge axi_clk); #1 ini_bvalid = 1'b0;
  endtask

  task automatic send_r(input logic [7:0] id, input logic last, input logic [DW-1:0] d);
    bit ok = 1'b0;
    ini_rid = id; ini_rresp = 2'b00; ini_rlast = last; ini_rdata = d; ini_rvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge axi_clk);
      if (ini_rready) begin ok = 1'b1; break; end
    end
    if (!ok) begin total++; $display("FAIL send_r_timeout: rready=0, expected 1"); end
    @(posedge axi_clk); #1 ini_rvalid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge axi_clk);
      if (!a2l_valid) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || sb.size() != 0) $display("FAIL drain: a2l_valid=%b left=%0d, expected 0/0", a2l_valid, sb.size());
    else passed++;
    @(posedge axi_clk); #1;
  endtask

  task automatic test_reset();
    @(posedge axi_clk); #1 axi_reset = 1'b0;
    repeat (2) @(posedge axi_clk);
    @(negedge axi_clk);
    total++;
    if ({a2l_valid, a2l_data, ini_bready, ini_rready, b_count, r_count, busy} !== '0)
      $display("FAIL reset_outputs: valid=%b data=%h brdy=%b rrdy=%b bc=%h rc=%h busy=%b, expected all 0",
               a2l_valid, a2l_data, ini_bready, ini_rready, b_count, r_count, busy);
    else passed++;
    hold_reset(1);
  endtask

  task automatic test_lone_b();
    a2l_ready = 1'b1;
    send_b(8'h5A, 2'b10);
    @(negedge axi_clk);
    total++;
    if (a2l_valid !== 1'b1 || a2l_data !== mk_b(8'h5A, 2'b10))
      $display("FAIL lone_b_latency: valid=%b data=%h, expected 1 %h", a2l_valid, a2l_data, mk_b(8'h5A, 2'b10));
    else passed++;
    total++;
    if (b_count !== 16'd1) $display("FAIL lone_b_count: got %0d, expected 1", b_count);
    else passed++;
    @(posedge axi_clk); #1;
    drain();
  endtask

  task automatic test_r_burst();
    int base;
    bit ok = 1'b0;
    base = out_dt.size();
    send_r(8'd3, 1'b0, 64'd1);
    ini_bid = 8'h77; ini_bresp = 2'b00; ini_bvalid = 1'b1;
    send_r(8'd3, 1'b0, 64'd2);
    send_r(8'd3, 1'b0, 64'd3);
    send_r(8'd3, 1'b1, 64'd4);
    for (int i = 0; i < 50; i++) begin
      @(negedge axi_clk);
      if (ini_bready) begin ok = 1'b1; break; end
    end
    @(posedge axi_clk); #1 ini_bvalid = 1'b0;
    total++;
    if (!ok) $display("FAIL burst_b_timeout: bready=0, expected 1"); else passed++;
    drain();
    total++;
    if (out_dt.size() != base + 5) $display("FAIL burst_words: got %0d, expected 5", out_dt.size() - base);
    else begin
      passed++;
      for (int i = 0; i < 5; i++) begin
        total++;
        if (out_dt[base+i] !== ((i < 4) ? 8'h24 : 8'h22) || out_last[base+i] !== (i == 3))
          $display("FAIL burst_order[%0d]: dt=%h last=%b, expected %h %b", i, out_dt[base+i],
                   out_last[base+i], (i < 4) ? 8'h24 : 8'h22, i == 3);
        else passed++;
      end
    end
    total++;
    if (r_count !== 16'd4) $display("FAIL burst_rcount: got %0d, expected 4", r_count);
    else passed++;
  endtask

  task automatic test_alternate();
    int acc = 0;
    hold_reset(2);
    ini_bid = 8'h01; ini_rid = 8'h02; ini_rlast = 1'b1; ini_rdata = 64'hA5A5;
    ini_bvalid = 1'b1; ini_rvalid = 1'b1;
    for (int i = 0; i < 100 && acc < 8; i++) begin
      @(negedge axi_clk);
      acc += int'(ini_bvalid && ini_bready) + int'(ini_rvalid && ini_rready);
    end
    @(posedge axi_clk); #1 ini_bvalid = 1'b0; ini_rvalid = 1'b0;
    drain();
    total++;
    if (out_dt.size() != 8) $display("FAIL alt_words: got %0d, expected 8", out_dt.size());
    else begin
      passed++;
      for (int i = 0; i < 8; i++) begin
        total++;
        if (out_dt[i] !== ((i % 2 == 0) ? 8'h22 : 8'h24))
          $display("FAIL alt_order[%0d]: dt=%h, expected %h", i, out_dt[i], (i % 2 == 0) ? 8'h22 : 8'h24);
        else passed++;
      end
    end
  endtask

  task automatic test_stall();
    int acc = 0;
    int base;
    base = out_dt.size();
    a2l_ready = 1'b0;
    ini_bid = 8'h31; ini_rid = 8'h32; ini_rlast = 1'b1; ini_rdata = 64'h1234;
    ini_bvalid = 1'b1; ini_rvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge axi_clk);
      acc += int'(ini_bvalid && ini_bready) + int'(ini_rvalid && ini_rready);
    end
    total++;
    if (acc != 2 || ini_bready !== 1'b0 || ini_rready !== 1'b0)
      $display("FAIL stall_accept: got %0d beats brdy=%b rrdy=%b, expected 2 0 0", acc, ini_bready, ini_rready);
    else passed++;
    @(posedge axi_clk); #1 ini_bvalid = 1'b0; ini_rvalid = 1'b0; a2l_ready = 1'b1;
    drain();
    total++;
    if (out_dt.size() != base + 2) $display("FAIL stall_words: got %0d, expected 2", out_dt.size() - base);
    else passed++;
  endtask

  task automatic test_enable();
    int acc = 0;
    a2l_ready = 1'b0;
    ini_bvalid = 1'b1; ini_rvalid = 1'b1; ini_rlast = 1'b1;
    for (int i = 0; i < 20 && acc < 2; i++) begin
      @(negedge axi_clk);
      acc += int'(ini_bvalid && ini_bready) + int'(ini_rvalid && ini_rready);
    end
    @(posedge axi_clk); #1 enable = 1'b0; a2l_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge axi_clk);
      acc += int'(ini_bvalid && ini_bready) + int'(ini_rvalid && ini_rready);
    end
    total++;
    if (acc != 0 || a2l_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL enable_drain: beats=%0d valid=%b busy=%b, expected 0 0 0", acc, a2l_valid, busy);
    else passed++;
    @(posedge axi_clk); #1 ini_bvalid = 1'b0; ini_rvalid = 1'b0; enable = 1'b1;
    send_r(8'd9, 1'b0, 64'd99);
    enable = 1'b0;
    repeat (5) @(negedge axi_clk);
    total++;
    if (a2l_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL enable_rlock_busy: valid=%b busy=%b, expected 0 1", a2l_valid, busy);
    else passed++;
    @(posedge axi_clk); #1 enable = 1'b1;
    send_r(8'd9, 1'b1, 64'd100);
    drain();
    total++;
    if (busy !== 1'b0) $display("FAIL enable_unlock: busy=%b, expected 0", busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    a2l_ready = 1'b0;
    send_b(8'h11, 2'b01);
    @(negedge axi_clk);
    total++;
    if (a2l_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b, expected 1", a2l_valid);
    else passed++;
    hold_reset(2);
    @(negedge axi_clk);
    total++;
    if (a2l_valid !== 1'b0 || b_count !== 16'd0 || r_count !== 16'd0)
      $display("FAIL mid_post_reset: valid=%b bc=%0d rc=%0d, expected 0 0 0", a2l_valid, b_count, r_count);
    else passed++;
    @(posedge axi_clk); #1 a2l_ready = 1'b1;
    send_b(8'hC3, 2'b01);
    @(negedge axi_clk);
    total++;
    if (a2l_valid !== 1'b1 || a2l_data !== mk_b(8'hC3, 2'b01))
      $display("FAIL mid_first_beat: valid=%b data=%h, expected 1 %h", a2l_valid, a2l_data, mk_b(8'hC3, 2'b01));
    else passed++;
    @(posedge axi_clk); #1;
    drain();
  endtask

  task automatic test_wrap();
    hold_reset(2);
    a2l_ready = 1'b1;
    for (int i = 0; i < 65535; i++) send_b(8'(i), 2'(i));
    total++;
    if (b_count !== 16'hFFFF) $display("FAIL wrap_max: got %h, expected ffff", b_count);
    else passed++;
    send_b(8'hEE, 2'b11);
    total++;
    if (b_count !== 16'h0000) $display("FAIL wrap_zero: got %h, expected 0000", b_count);
    else passed++;
    drain();
  endtask

  initial begin
    test_reset();
    test_lone_b();
    test_r_burst();
    test_alternate();
    test_stall();
    test_enable();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
